fa_bist: RTL
============

# fa_bist

Built-in self-test engine for a single-bit full adder. It drives the adder's A/B/Cin inputs through all 8 input patterns and samples the adder's Sum/Cout after a programmable settle time. Each response is compared against the expected full-adder function, and the block reports per-pattern failures and a pass/fail summary. It sits beside any FA instance in the adders library and is the synthesizable checking counterpart of the FA simulation stimulus.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles spent in SETTLE per pattern before sampling; legal range 1..15.

Ports:
- clk, input, 1: single clock, all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin a test run; sampled only in IDLE or DONE.
- a_out, output, 1: drives FA input A.
- b_out, output, 1: drives FA input B.
- cin_out, output, 1: drives FA input Cin.
- sum_in, input, 1: FA Sum response.
- cout_in, input, 1: FA Cout response.
- busy, output, 1: high in SETTLE or CHECK.
- done, output, 1: high in DONE.
- pass, output, 1: high in DONE when err_count == 0.
- fail_vec, output, 8: bit i set if pattern i mismatched.
- err_count, output, 4: number of mismatched patterns, 0..8.

## Operation
- The pattern index idx is 3 bits. While busy: a_out = idx[2], b_out = idx[1], cin_out = idx[0]. In IDLE and DONE all three outputs are 0.
- Expected response for pattern idx: exp_sum = XOR of the three bits; exp_cout = majority of the three bits.
- IDLE: start=1 → SETTLE, with idx = 0 and settle count cnt = SETTLE_CYCLES-1. Results are cleared at this transition.
- SETTLE: if cnt == 0 → CHECK; otherwise decrement cnt.
- CHECK: sample sum_in/cout_in. A mismatch on either bit sets fail_vec[idx] and increments err_count. Then:
  - if idx == 7 → DONE;
  - otherwise idx increments and the block returns to SETTLE with cnt reloaded.
- DONE: outputs hold their values. start=1 restarts exactly as from IDLE: fail_vec and err_count are cleared and idx = 0.
- start while busy is ignored.
- err_count saturates naturally at 8 because there are only 8 patterns; it cannot wrap.
- Inputs sum_in/cout_in are used only in CHECK and have no effect in any other state.

## Timing
- Reset values: state = IDLE, idx = 0, cnt = 0, a_out/b_out/cin_out = 0, busy = 0, done = 0, pass = 0, fail_vec = 8'h00, err_count = 0.
- Reset overrides start and has priority in every state. Reset mid-run returns the block to IDLE within one edge and discards partial results.
- Each pattern occupies SETTLE_CYCLES + 1 clock cycles: SETTLE_CYCLES in SETTLE, then 1 in CHECK.
- Pattern outputs change on the edge that enters SETTLE, so the FA has at least SETTLE_CYCLES full cycles to settle before sampling.
- done rises 8*(SETTLE_CYCLES+1) edges after the edge that sampled start. For SETTLE_CYCLES = 1, that is 16 edges.
- busy rises on the edge after start is sampled and falls on the edge that sets done.
- pass is registered and updates together with done. fail_vec and err_count update on the edge that leaves CHECK.

## Configuration
- FA_BIST_STOP_ON_FAIL_EN defined: a mismatch in CHECK goes directly to DONE. fail_vec then has exactly one bit set, err_count = 1, and the remaining patterns are not applied.
- FA_BIST_STOP_ON_FAIL_EN undefined (default): all 8 patterns always run, regardless of mismatches.

## Test plan
- Correct FA model, SETTLE_CYCLES = 1, pulse start: done = 1 and pass = 1 at edge 16, fail_vec = 8'h00, err_count = 0. a_out/b_out/cin_out step through 000..111.
- Cout stuck at 0: fail_vec = 8'hE8 (patterns 3, 5, 6, 7), err_count = 4, pass = 0.
- Sum inverted: fail_vec = 8'hFF, err_count = 8, pass = 0.
- Hold start high through the whole run, then pulse start again from DONE:
  - holding start does not restart the run while busy;
  - the pulse from DONE clears results and completes a second identical run.
- Assert reset at edge 7 of a run: all outputs return to their reset values on the next edge, and a later start runs cleanly.
- FA_BIST_STOP_ON_FAIL_EN defined, Cout stuck at 0, SETTLE_CYCLES = 1: done at edge 8, fail_vec = 8'h08, err_count = 1.

Source files
------------

// File: rtl/fa_bist.sv
// rtl/fa_bist.sv - Self-test engine that walks a full adder through all 8 input patterns.
// Optional macro FA_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching pattern.
module fa_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    output logic       cin_out,
    input  logic       sum_in,
    input  logic       cout_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_vec,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] idx, idx_next;
    logic [3:0] cnt, cnt_next;
    logic [7:0] fail_vec_next;
    logic [3:0] err_count_next;
    logic       pass_next;

    logic exp_sum;
    logic exp_cout;
    logic mismatch;

    assign exp_sum  = idx[2] ^ idx[1] ^ idx[0];
    assign exp_cout = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    assign mismatch = (sum_in != exp_sum) || (cout_in != exp_cout);

    assign busy    = (state == SETTLE) || (state == CHECK);
    assign done    = (state == DONE);
    assign a_out   = busy & idx[2];
    assign b_out   = busy & idx[1];
    assign cin_out = busy & idx[0];

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        cnt_next       = cnt;
        fail_vec_next  = fail_vec;
        err_count_next = err_count;
        pass_next      = pass;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = SETTLE;
                    idx_next       = 3'd0;
                    cnt_next       = CNT_LOAD;
                    fail_vec_next  = 8'h00;
                    err_count_next = 4'd0;
                    pass_next      = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_vec_next[idx] = 1'b1;
                    err_count_next     = err_count + 4'd1;
                end
`ifdef FA_BIST_STOP_ON_FAIL_EN
                if (idx == 3'd7 || mismatch) begin
`else
                if (idx == 3'd7) begin
`endif
                    state_next = DONE;
                    pass_next  = (err_count_next == 4'd0);
                end else begin
                    state_next = SETTLE;
                    idx_next   = idx + 3'd1;
                    cnt_next   = CNT_LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            fail_vec  <= 8'h00;
            err_count <= 4'd0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
            fail_vec  <= fail_vec_next;
            err_count <= err_count_next;
            pass      <= pass_next;
        end
    end

endmodule
